// File: rtl/lcd_write_arbiter_if.sv
// Request/response and LCD pin bundle for the two-requester LCD write arbiter.
// The master side issues write requests; the slave side is the arbiter.
interface lcd_write_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_rs;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] data;
  logic       init_done;
  logic       busy;
  logic       grant_id;

  modport master (
    output req_valid, req_rs, req_data0, req_data1,
    input  req_ready, rs, rw, en, data, init_done, busy, grant_id
  );

  modport slave (
    input  req_valid, req_rs, req_data0, req_data1,
    output req_ready, rs, rw, en, data, init_done, busy, grant_id
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// HD44780-style LCD write sequencer: power-up wait, fixed init string,
// then round-robin arbitration of byte writes from two requesters.
//
// state      | meaning
// PWRUP      | idle after reset, en low
// INIT_SETUP | init byte on bus, en low
// INIT_PULSE | init byte strobe, en high
// INIT_WAIT  | post-write delay for init byte
// IDLE       | accepting requests (ready pulse, then SETUP)
// SETUP      | user byte on bus, en low
// PULSE      | user byte strobe, en high
// WAIT       | post-write delay for user byte
module lcd_write_arbiter #(
  parameter int unsigned PWRUP_CYCLES     = 1000000,
  parameter int unsigned EN_CYCLES        = 25,
  parameter int unsigned DELAY_CYCLES     = 50000,
  parameter int unsigned CLR_DELAY_CYCLES = 100000
) (
  input logic                clk,
  input logic                reset,
  lcd_write_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    PWRUP, INIT_SETUP, INIT_PULSE, INIT_WAIT, IDLE, SETUP, PULSE, WAIT
  } state_t;

  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYCLES - 1);
  localparam logic [31:0] EN_LAST    = 32'(EN_CYCLES - 1);
  localparam logic [31:0] DELAY_LAST = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_DELAY_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [1:0]  init_idx, init_idx_nxt;
  logic        last_gnt;
  logic [1:0]  ready_q;
  logic        rs_q, en_q, init_done_q, busy_q, grant_q;
  logic [7:0]  data_q;

  logic [7:0]  init_byte;
  logic [31:0] wait_last;
  logic        win;
  logic        accept;

  always_comb begin
    init_idx_nxt = init_idx;
    if (state == INIT_WAIT && state_nxt == INIT_SETUP)
      init_idx_nxt = init_idx + 2'd1;
    case (init_idx_nxt)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  end

  // Clear and home need the long settle time; everything else the short one.
  always_comb begin
    wait_last = DELAY_LAST;
    if (!rs_q && (data_q == 8'h01 || data_q == 8'h02))
      wait_last = CLR_LAST;
  end

  always_comb begin
    win = ~last_gnt;
    if (bus.req_valid == 2'b01) win = 1'b0;
    else if (bus.req_valid == 2'b10) win = 1'b1;
    accept = (state == IDLE) && init_done_q && (ready_q == 2'b00) && (|bus.req_valid);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PWRUP:      if (cnt == PWRUP_LAST) state_nxt = INIT_SETUP;
      INIT_SETUP: state_nxt = INIT_PULSE;
      INIT_PULSE: if (cnt == EN_LAST) state_nxt = INIT_WAIT;
      INIT_WAIT:  if (cnt == wait_last) state_nxt = (init_idx == 2'd3) ? IDLE : INIT_SETUP;
      IDLE:       if (|ready_q) state_nxt = SETUP;
      SETUP:      state_nxt = PULSE;
      PULSE:      if (cnt == EN_LAST) state_nxt = WAIT;
      WAIT:       if (cnt == wait_last) state_nxt = IDLE;
      default:    state_nxt = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= PWRUP;
      cnt         <= '0;
      init_idx    <= 2'd0;
      last_gnt    <= 1'b1;
      ready_q     <= 2'b00;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      grant_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;
      init_idx <= init_idx_nxt;
      en_q     <= (state_nxt == INIT_PULSE) || (state_nxt == PULSE);
      busy_q   <= (state_nxt != IDLE);
      ready_q  <= accept ? (win ? 2'b10 : 2'b01) : 2'b00;
      if (accept) begin
        grant_q  <= win;
        last_gnt <= win;
      end
      if (state_nxt == INIT_SETUP && state != INIT_SETUP) begin
        rs_q   <= 1'b0;
        data_q <= init_byte;
      end
      // Byte is captured on the ready cycle and held until WAIT exits.
      if (state == IDLE && state_nxt == SETUP) begin
        rs_q   <= grant_q ? bus.req_rs[1] : bus.req_rs[0];
        data_q <= grant_q ? bus.req_data1 : bus.req_data0;
      end
      if (state == INIT_WAIT && state_nxt == IDLE)
        init_done_q <= 1'b1;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rs        = rs_q;
  assign bus.rw        = 1'b0;
  assign bus.en        = en_q;
  assign bus.data      = data_q;
  assign bus.init_done = init_done_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with short timing parameters
// (PWRUP=5, EN=2, DELAY=4, CLR_DELAY=8).
module tb_lcd_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lcd_write_arbiter_if bus();

  lcd_write_arbiter #(
    .PWRUP_CYCLES(5), .EN_CYCLES(2), .DELAY_CYCLES(4), .CLR_DELAY_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with en high; leaves at the first negedge with en low.
  task automatic pulse_check(input string tag, input logic exp_rs, input logic [7:0] exp_data);
    int   n = 0;
    logic stable = 1'b1;
    chk({tag, "_rs"}, 32'(bus.rs), 32'(exp_rs));
    chk({tag, "_data"}, 32'(bus.data), 32'(exp_data));
    chk({tag, "_rw"}, 32'(bus.rw), 32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    while (bus.en === 1'b1 && n < 100) begin
      if (bus.rs !== exp_rs || bus.data !== exp_data) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    chk({tag, "_en_len"}, 32'(n), 32'd2);
    chk({tag, "_stable"}, 32'(stable), 32'd1);
  endtask

  // Counts en-low busy cycles until en rises again or busy drops.
  task automatic gap_count(input string tag, input int exp);
    int n = 0;
    while (bus.en === 1'b0 && bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  // Called at the negedge where reset was just released.
  task automatic check_init();
    int n = 0;
    while (bus.en !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("pwrup_to_en", 32'(n), 32'd6);
    chk("init_done_early", 32'(bus.init_done), 32'd0);
    pulse_check("init38", 1'b0, 8'h38);
    gap_count("init38_gap", 5);
    pulse_check("init0c", 1'b0, 8'h0C);
    gap_count("init0c_gap", 5);
    pulse_check("init01", 1'b0, 8'h01);
    gap_count("init01_gap", 9);
    chk("init_done_mid", 32'(bus.init_done), 32'd0);
    pulse_check("init06", 1'b0, 8'h06);
    gap_count("init06_wait", 4);
    chk("init_done", 32'(bus.init_done), 32'd1);
    chk("init_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic xfer(input string tag, input logic [1:0] exp_ready, input logic exp_gid,
                      input logic exp_rs, input logic [7:0] exp_data, input int exp_wait,
                      input logic drop);
    int n = 0;
    while (bus.req_ready === 2'b00 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
    chk({tag, "_ready_init"}, 32'(bus.init_done), 32'd1);
    chk({tag, "_ready_busy"}, 32'(bus.busy), 32'd0);
    if (drop) bus.req_valid = 2'b00;
    @(negedge clk);
    chk({tag, "_ready_off"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_gid"}, 32'(bus.grant_id), 32'(exp_gid));
    chk({tag, "_setup_rs"}, 32'(bus.rs), 32'(exp_rs));
    chk({tag, "_setup_data"}, 32'(bus.data), 32'(exp_data));
    chk({tag, "_setup_en"}, 32'(bus.en), 32'd0);
    chk({tag, "_setup_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    pulse_check(tag, exp_rs, exp_data);
    gap_count({tag, "_wait"}, exp_wait);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    bus.req_valid = 2'b00;
    bus.req_rs    = 2'b00;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(bus.en), 32'd0);
    chk("rst_rs", 32'(bus.rs), 32'd0);
    chk("rst_rw", 32'(bus.rw), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_gid", 32'(bus.grant_id), 32'd0);
    reset = 1'b1;
    check_init();

    // Single data write from requester 0.
    bus.req_valid = 2'b01;
    bus.req_rs    = 2'b01;
    bus.req_data0 = 8'h57;
    xfer("w57", 2'b01, 1'b0, 1'b1, 8'h57, 4, 1'b1);

    // Clear command takes the long wait; entry-mode command the short one.
    bus.req_valid = 2'b10;
    bus.req_rs    = 2'b00;
    bus.req_data1 = 8'h01;
    xfer("clr", 2'b10, 1'b1, 1'b0, 8'h01, 8, 1'b1);
    bus.req_valid = 2'b10;
    bus.req_data1 = 8'h06;
    xfer("ent", 2'b10, 1'b1, 1'b0, 8'h06, 4, 1'b1);

    // Both requesters held valid: grants alternate starting with 0.
    bus.req_rs    = 2'b11;
    bus.req_data0 = 8'h41;
    bus.req_data1 = 8'h42;
    bus.req_valid = 2'b11;
    xfer("rr0", 2'b01, 1'b0, 1'b1, 8'h41, 4, 1'b0);
    xfer("rr1", 2'b10, 1'b1, 1'b1, 8'h42, 4, 1'b0);
    xfer("rr2", 2'b01, 1'b0, 1'b1, 8'h41, 4, 1'b0);
    xfer("rr3", 2'b10, 1'b1, 1'b1, 8'h42, 4, 1'b0);

    // Reset in the middle of the next strobe.
    n = 0;
    while (bus.en !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("abort_en_seen", 32'(bus.en), 32'd1);
    chk("abort_data", 32'(bus.data), 32'h41);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_en", 32'(bus.en), 32'd0);
    chk("abort_init_done", 32'(bus.init_done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    chk("abort_data_clr", 32'(bus.data), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;

    // Requests pending through re-init are served after it, requester 0 first.
    check_init();
    xfer("post0", 2'b01, 1'b0, 1'b1, 8'h41, 4, 1'b0);
    xfer("post1", 2'b10, 1'b1, 1'b1, 8'h42, 4, 1'b1);

    repeat (3) @(negedge clk);
    chk("final_ready", 32'(bus.req_ready), 32'd0);
    chk("final_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
